// File: rtl/full_adder.sv
// Ripple-carry full adder of WIDTH bits with an optional one-cycle output register.
// The result is qualified by a valid strobe: registered (REGISTERED=1) or combinational (REGISTERED=0).
module full_adder #(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_comb;
  logic             carry_comb;

  // The carry is walked bit by bit through a scalar, so the chain has no
  // self-dependent vector and each step is a textbook 1-bit cell.
  always_comb begin
    logic k;
    sum_comb = '0;
    k        = c;
    for (int i = 0; i < WIDTH; i++) begin
      sum_comb[i] = a[i] ^ b[i] ^ k;
      k           = (a[i] & b[i]) | (a[i] & k) | (b[i] & k);
    end
    carry_comb = k;
  end

  generate
    if (REGISTERED) begin : g_registered
      logic [WIDTH-1:0] sum_q;
      logic             carry_q;
      logic             valid_q;

      // Reset wins over in_valid; without in_valid the data holds and valid drops.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q   <= '0;
          carry_q <= 1'b0;
          valid_q <= 1'b0;
        end else if (in_valid) begin
          sum_q   <= sum_comb;
          carry_q <= carry_comb;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end

      assign sum       = sum_q;
      assign carry     = carry_q;
      assign out_valid = valid_q;
    end else begin : g_combinational
      assign sum       = sum_comb;
      assign carry     = carry_comb;
      assign out_valid = in_valid & ~rst;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: directed truth-table, boundary, reset and gating tests on small
// instances, then a random stream on an 8-bit registered instance checked by a scoreboard.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // WIDTH=1 registered
  logic       v1r = 1'b0, a1r = 1'b0, b1r = 1'b0, c1r = 1'b0;
  logic       s1r, k1r, o1r;
  // WIDTH=1 combinational
  logic       v1c = 1'b0, a1c = 1'b0, b1c = 1'b0, c1c = 1'b0;
  logic       s1c, k1c, o1c;
  // WIDTH=4 registered
  logic       v4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       k4, o4;
  // WIDTH=8 registered
  logic       v8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       k8, o8;

  full_adder #(.WIDTH(1), .REGISTERED(1'b1)) u_w1r (
    .clk(clk), .rst(rst), .in_valid(v1r), .a(a1r), .b(b1r), .c(c1r),
    .sum(s1r), .carry(k1r), .out_valid(o1r));
  full_adder #(.WIDTH(1), .REGISTERED(1'b0)) u_w1c (
    .clk(clk), .rst(rst), .in_valid(v1c), .a(a1c), .b(b1c), .c(c1c),
    .sum(s1c), .carry(k1c), .out_valid(o1c));
  full_adder #(.WIDTH(4), .REGISTERED(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c(c4),
    .sum(s4), .carry(k4), .out_valid(o4));
  full_adder #(.WIDTH(8), .REGISTERED(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .sum(s8), .carry(k8), .out_valid(o8));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard for the 8-bit instance: {out_valid, carry, sum} expected per cycle.
  logic [9:0] exp_q[$];

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      check("w8_valid", 64'(o8), 64'(e[9]));
      check("w8_result", 64'({k8, s8}), 64'(e[8:0]));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] held;
    logic       r, v;
    int         total;

    // Reset: registered outputs are all zero.
    repeat (2) @(negedge clk);
    check("rst_w1_out", 64'({o1r, k1r, s1r}), 64'd0);
    check("rst_w4_out", 64'({o4, k4, s4}), 64'd0);
    check("rst_w8_out", 64'({o8, k8, s8}), 64'd0);
    rst = 1'b0;

    // WIDTH=1 registered truth table, back to back.
    for (int i = 0; i < 8; i++) begin
      {a1r, b1r, c1r} = 3'(i);
      v1r = 1'b1;
      @(negedge clk);
      total = (i >> 2) + ((i >> 1) & 1) + (i & 1);
      check($sformatf("w1r_sum_%0d", i), 64'(s1r), 64'(total % 2));
      check($sformatf("w1r_carry_%0d", i), 64'(k1r), 64'(total / 2));
      check($sformatf("w1r_valid_%0d", i), 64'(o1r), 64'd1);
    end
    v1r = 1'b0;

    // WIDTH=1 combinational truth table, no clock edge needed.
    for (int i = 0; i < 8; i++) begin
      {a1c, b1c, c1c} = 3'(i);
      v1c = i[0];
      #1;
      total = (i >> 2) + ((i >> 1) & 1) + (i & 1);
      check($sformatf("w1c_sum_%0d", i), 64'(s1c), 64'(total % 2));
      check($sformatf("w1c_carry_%0d", i), 64'(k1c), 64'(total / 2));
      check($sformatf("w1c_valid_%0d", i), 64'(o1c), 64'(i % 2));
      #9;
    end
    rst = 1'b1;
    v1c = 1'b1;
    #1;
    check("w1c_valid_in_rst", 64'(o1c), 64'd0);
    check("w1c_sum_in_rst", 64'({k1c, s1c}), 64'(total));
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=4 boundary values.
    a4 = 4'd15; b4 = 4'd1; c4 = 1'b1; v4 = 1'b1;
    @(negedge clk);
    check("w4_15_1_1", 64'({o4, k4, s4}), 64'({1'b1, 1'b1, 4'd1}));
    a4 = 4'd7; b4 = 4'd8; c4 = 1'b0;
    @(negedge clk);
    check("w4_7_8_0", 64'({o4, k4, s4}), 64'({1'b1, 1'b0, 4'd15}));
    a4 = 4'd15; b4 = 4'd15; c4 = 1'b1;
    @(negedge clk);
    check("w4_all_ones", 64'({o4, k4, s4}), 64'({1'b1, 1'b1, 4'd15}));
    a4 = 4'd0; b4 = 4'd0; c4 = 1'b0;
    @(negedge clk);
    check("w4_all_zero", 64'({o4, k4, s4}), 64'({1'b1, 1'b0, 4'd0}));

    // Reset mid-operation with in_valid held high.
    a4 = 4'd1; b4 = 4'd1; c4 = 1'b0; v4 = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("w4_mid_rst", 64'({o4, k4, s4}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("w4_after_rst", 64'({o4, k4, s4}), 64'({1'b1, 1'b0, 4'd2}));
    a4 = 4'd8; b4 = 4'd8; c4 = 1'b0;
    @(negedge clk);
    check("w4_carry_only", 64'({o4, k4, s4}), 64'({1'b1, 1'b1, 4'd0}));

    // Valid gating: result holds while in_valid is low.
    a4 = 4'd1; b4 = 4'd0; c4 = 1'b0; v4 = 1'b1;
    @(negedge clk);
    check("w4_gate_load", 64'({o4, k4, s4}), 64'({1'b1, 1'b0, 4'd1}));
    a4 = 4'd1; b4 = 4'd1; c4 = 1'b1; v4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("w4_gate_hold_%0d", i), 64'({o4, k4, s4}), 64'({1'b0, 1'b0, 4'd1}));
    end

    // WIDTH=8 random stream with occasional resets.
    held = '0;
    @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      #1;
      r  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      if (n % 97 == 5) begin
        a8 = 8'hff; b8 = 8'hff; c8 = 1'b1; v = 1'b1; r = 1'b0;
      end
      v8  = v;
      rst = r;
      if (r) begin
        held = '0;
        exp_q.push_back({1'b0, held});
      end else if (v) begin
        held = 9'(a8) + 9'(b8) + 9'(c8);
        exp_q.push_back({1'b1, held});
      end else begin
        exp_q.push_back({1'b0, held});
      end
      @(negedge clk);
    end
    #1;
    v8  = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("w8_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
